// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction-store loader and its byte RAM.
package instr_mem_pkg;

    localparam int DEFAULT_DEPTH = 72;
    localparam int DEFAULT_CNT_W = 16;
    localparam int BYTE_W        = 8;
    localparam int WORD_W        = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK,
        FIN
    } state_t;

endpackage

// File: rtl/instr_byte_ram.sv
// DEPTH x 8 instruction store: one synchronous byte write port and a combinational
// big-endian 4-byte read port; bytes past the end of the store read as zero.
module instr_byte_ram
    import instr_mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [BYTE_W-1:0]        i_wdata,
    input  logic [WORD_W-1:0]        i_raddr,
    output logic [WORD_W-1:0]        o_rdata
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [BYTE_W-1:0] r_mem [DEPTH];

    // NOTE: the array has no reset branch so it maps onto plain RAM/flops without
    // a reset network; contents survive rst_n, and <= keeps the write ordered
    // against same-cycle readers.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Each lane computes its byte address at 33 bits so a+3 never wraps into range.
    for (genvar lane = 0; lane < 4; lane++) begin : g_lane
        logic [WORD_W:0] w_addr;

        assign w_addr = {1'b0, i_raddr} + (WORD_W + 1)'(lane);
        assign o_rdata[WORD_W-1-BYTE_W*lane -: BYTE_W] =
            (w_addr < (WORD_W + 1)'(DEPTH)) ? r_mem[w_addr[ADDR_W-1:0]] : '0;
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Stream loader for the byte-addressed instruction store plus its 32-bit fetch port.
// Define LOADER_CHECKSUM_EN to add a trailing checksum byte checked in the CHECK state.
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  byte_cnt,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [WORD_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    localparam int ADDR_W = $clog2(DEPTH);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_ptr;
    logic [CNT_W-1:0]    r_rem;
    logic                r_err;
    logic [WORD_W:0]     w_end;
    logic                w_fits;
    logic                w_hs;
    logic                w_last;
    logic                w_we;
`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]   r_sum;
`endif

    // End of the requested range, widened so a huge base cannot wrap back into range.
    assign w_end  = {1'b0, base_addr} + (WORD_W + 1)'(byte_cnt);
    assign w_fits = (w_end <= (WORD_W + 1)'(DEPTH));
    assign w_hs   = in_valid & in_ready;
    assign w_last = (r_rem == CNT_W'(1));
    assign w_we   = (r_state == LOAD) & w_hs & ~abort;
    assign err    = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every combinational output gets a default before the case so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (byte_cnt != '0 && w_fits) ? LOAD : FIN;
                end
            end
            LOAD: begin
                if (abort) begin
                    w_next = FIN;
                end else if (w_hs && w_last) begin
`ifdef LOADER_CHECKSUM_EN
                    w_next = CHECK;
`else
                    w_next = FIN;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (abort || w_hs) begin
                    w_next = FIN;
                end
            end
`endif
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
`endif
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_rem <= '0;
            r_err <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_sum <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ptr <= base_addr[ADDR_W-1:0];
                        r_rem <= byte_cnt;
                        // An empty load is never an overflow, whatever the base.
                        r_err <= (byte_cnt != '0) && !w_fits;
`ifdef LOADER_CHECKSUM_EN
                        r_sum <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (abort) begin
                        r_err <= 1'b1;
                    end else if (w_hs) begin
                        r_ptr <= r_ptr + ADDR_W'(1);
                        r_rem <= r_rem - CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                        r_sum <= r_sum + in_data;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (abort) begin
                        r_err <= 1'b1;
                    end else if (w_hs && (BYTE_W'(r_sum + in_data) != '0)) begin
                        r_err <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    instr_byte_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_ptr),
        .i_wdata (in_data),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader; handles both builds of LOADER_CHECKSUM_EN.
module tb_instr_mem_loader;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start     = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] byte_cnt  = '0;
    logic        abort     = 1'b0;
    logic        in_valid  = 1'b0;
    logic [7:0]  in_data   = '0;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rd_addr   = '0;
    logic [31:0] rd_data;

    int n_checks = 0;
    int n_errs   = 0;

    instr_mem_loader #(
        .DEPTH (72),
        .CNT_W (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .byte_cnt  (byte_cnt),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        rd_addr = addr;
        #1;
        check(tag, rd_data, exp);
    endtask

    task automatic start_load(input logic [31:0] b, input logic [15:0] c);
        start     = 1'b1;
        base_addr = b;
        byte_cnt  = c;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input string tag, input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        check({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    // Streams the first n bytes of w (MSB first), appends the checksum byte in that
    // build, then expects a clean one-cycle done.
    task automatic load_word(input string tag, input logic [31:0] b, input int n,
                             input logic [31:0] w, input bit stall);
        logic [7:0] sum;
        logic [7:0] d;
        sum = 8'h00;
        start_load(b, 16'(n));
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        check({tag, "_errclr"}, {31'b0, err}, 32'd0);
        for (int k = 0; k < n; k++) begin
            d = w[31-8*k -: 8];
            if (stall) begin
                in_valid = 1'b0;
                step();
                check({tag, "_stallbusy"}, {31'b0, busy}, 32'd1);
            end
            send_byte(tag, d);
            sum = sum + d;
        end
`ifdef LOADER_CHECKSUM_EN
        check({tag, "_chkwait"}, {31'b0, done}, 32'd0);
        send_byte({tag, "_cks"}, 8'h00 - sum);
`endif
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_err"}, {31'b0, err}, 32'd0);
        check({tag, "_busyoff"}, {31'b0, busy}, 32'd0);
        step();
        check({tag, "_done1"}, {31'b0, done}, 32'd0);
        check({tag, "_rdyoff"}, {31'b0, in_ready}, 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_rdy", {31'b0, in_ready}, 32'd0);
        read_check("rd_oob_all", 32'd72, 32'h0000_0000);
        read_check("rd_huge", 32'hFFFF_FFFE, 32'h0000_0000);
        #10 rst_n = 1'b1;
        step();

        // Basic load, no stalls.
        load_word("basic", 32'd0, 4, 32'h012A_4020, 1'b0);
        read_check("basic_rd", 32'd0, 32'h012A_4020);

        // Back-pressure with in_valid low every other cycle.
        load_word("bp", 32'd4, 4, 32'hDEAD_BEEF, 1'b1);
        read_check("bp_rd", 32'd4, 32'hDEAD_BEEF);
        read_check("bp_straddle", 32'd2, 32'h4020_DEAD);

        // Overwrite byte 0: same-cycle read returns old data, next cycle the new byte.
        start_load(32'd0, 16'd1);
        rd_addr  = 32'd0;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        #1;
        check("samecyc_old", rd_data, 32'h012A_4020);
        step();
        in_valid = 1'b0;
        check("samecyc_new", rd_data, 32'hFF2A_4020);
`ifdef LOADER_CHECKSUM_EN
        send_byte("samecyc_cks", 8'h01);
`endif
        check("samecyc_done", {31'b0, done}, 32'd1);
        step();

        // Load that ends exactly at the last byte of the store.
        load_word("edge", 32'd68, 4, 32'h1122_3344, 1'b0);
        read_check("edge_rd", 32'd68, 32'h1122_3344);
        read_check("edge_tail", 32'd70, 32'h3344_0000);

        // Overflow: 70 + 4 > 72, nothing written.
        start_load(32'd70, 16'd4);
        check("ovf_done", {31'b0, done}, 32'd1);
        check("ovf_err", {31'b0, err}, 32'd1);
        check("ovf_rdy", {31'b0, in_ready}, 32'd0);
        check("ovf_busy", {31'b0, busy}, 32'd0);
        read_check("ovf_rd68", 32'd68, 32'h1122_3344);
        read_check("ovf_rd70", 32'd70, 32'h3344_0000);
        step();
        check("ovf_sticky", {31'b0, err}, 32'd1);

        // Abort together with the third handshake.
        load_word("pre8", 32'd8, 4, 32'h5566_7788, 1'b0);
        start_load(32'd8, 16'd4);
        send_byte("abt", 8'hA1);
        send_byte("abt", 8'hA2);
        in_valid = 1'b1;
        in_data  = 8'hA3;
        abort    = 1'b1;
        step();
        in_valid = 1'b0;
        abort    = 1'b0;
        check("abt_done", {31'b0, done}, 32'd1);
        check("abt_err", {31'b0, err}, 32'd1);
        read_check("abt_rd", 32'd8, 32'hA1A2_7788);
        step();
        check("abt_idle", {31'b0, done}, 32'd0);

        // Asynchronous reset in the middle of a load.
        start_load(32'd12, 16'd4);
        send_byte("rstmid", 8'hC1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_busy", {31'b0, busy}, 32'd0);
        check("rstmid_rdy", {31'b0, in_ready}, 32'd0);
        check("rstmid_err", {31'b0, err}, 32'd0);
        #1 rst_n = 1'b1;
        rd_addr = 32'd12;
        #1;
        check("rstmid_kept", {24'b0, rd_data[31:24]}, 32'h0000_00C1);
        step();

        // Zero-length load.
        start_load(32'd0, 16'd0);
        check("zero_done", {31'b0, done}, 32'd1);
        check("zero_err", {31'b0, err}, 32'd0);
        check("zero_rdy", {31'b0, in_ready}, 32'd0);
        step();
        check("zero_end", {31'b0, done}, 32'd0);

        // A start during LOAD is ignored.
        start_load(32'd16, 16'd2);
        start     = 1'b1;
        base_addr = 32'd0;
        byte_cnt  = 16'd0;
        step();
        start = 1'b0;
        check("ign_busy", {31'b0, busy}, 32'd1);
        check("ign_done", {31'b0, done}, 32'd0);
        send_byte("ign", 8'h9A);
        send_byte("ign", 8'hBC);
`ifdef LOADER_CHECKSUM_EN
        send_byte("ign_cks", 8'hAA);
`endif
        check("ign_fin", {31'b0, done}, 32'd1);
        check("ign_err", {31'b0, err}, 32'd0);
        read_check("ign_rd", 32'd16, {16'h9ABC, 16'h0000} | (rd_data & 32'h0000_FFFF));
        step();

`ifdef LOADER_CHECKSUM_EN
        // Checksum pass and fail; the checksum byte never lands in memory.
        load_word("pre20", 32'd20, 4, 32'h0000_0000, 1'b0);
        load_word("pre24", 32'd24, 4, 32'h0000_0000, 1'b0);
        start_load(32'd20, 16'd2);
        send_byte("ckok", 8'h10);
        send_byte("ckok", 8'h20);
        check("ckok_inchk", {31'b0, in_ready}, 32'd1);
        check("ckok_nodone", {31'b0, done}, 32'd0);
        send_byte("ckok_cks", 8'hD0);
        check("ckok_done", {31'b0, done}, 32'd1);
        check("ckok_err", {31'b0, err}, 32'd0);
        read_check("ckok_rd", 32'd20, 32'h1020_0000);
        step();
        start_load(32'd24, 16'd2);
        send_byte("ckbad", 8'h10);
        send_byte("ckbad", 8'h20);
        send_byte("ckbad_cks", 8'hD1);
        check("ckbad_done", {31'b0, done}, 32'd1);
        check("ckbad_err", {31'b0, err}, 32'd1);
        read_check("ckbad_rd", 32'd24, 32'h1020_0000);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
